ysyx_23060208_ifu_prefetch: RTL and testbench

YSYX_23060208_IFU_PREFETCH -- requirements
Module: ysyx_23060208_ifu_prefetch

---
 rtl/ysyx_23060208_ifu_prefetch.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_23060208_ifu_prefetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_ifu_prefetch.sv
// Instruction prefetcher: keeps at most one read in flight on the instruction SRAM
// read channel and queues returned instructions, tagged with their PC, in a small FIFO.
module ysyx_23060208_ifu_prefetch #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           FIFO_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic [DATA_WIDTH-1:0] isram_araddr,
   output logic                  isram_arvalid,
   input  logic                  isram_arready,
   input  logic [DATA_WIDTH-1:0] isram_rdata,
   input  logic [1:0]            isram_rresp,
   input  logic                  isram_rvalid,
   output logic                  isram_rready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic                  out_err
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = 2 * DATA_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      RESP,
      HALT
   } state_t;

   state_t                state_q, state_d;
   logic                  arvalid_q, arvalid_d;
   logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic                  discard_q, discard_d;
   logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0]    mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W:0]        occupancy;
   logic                  room;
   logic                  push;
   logic                  pop;
   logic                  beat_err;
   logic [ENTRY_W-1:0]    head;

   // The in-flight read reserves a slot so an accepted beat always fits.
   assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, (state_q == RESP)};
   assign room      = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
   assign beat_err  = (isram_rresp != 2'b00);

   always_comb begin
      state_d    = state_q;
      arvalid_d  = arvalid_q;
      araddr_d   = araddr_q;
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      push       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
            end else if (room) begin
               state_d   = ADDR;
               arvalid_d = 1'b1;
               araddr_d  = fetch_pc_q;
            end
         end
         ADDR: begin
            if (redirect_valid) begin
               discard_d  = 1'b1;
               fetch_pc_d = redirect_pc;
            end
            if (isram_arready) begin
               state_d   = RESP;
               arvalid_d = 1'b0;
               // A redirected fetch keeps the new PC instead of advancing past the dead read.
               if (!redirect_valid && !discard_q) begin
                  fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
               end
            end
         end
         RESP: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
            end
            if (isram_rvalid) begin
               if (redirect_valid || discard_q) begin
                  discard_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  push    = 1'b1;
                  state_d = beat_err ? HALT : IDLE;
               end
            end else if (redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         HALT: begin
            if (redirect_valid) begin
               state_d    = IDLE;
               fetch_pc_d = redirect_pc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop      = (count_q != '0) && out_ready;
      if (push) begin
         mem_d[wr_ptr_q] = {araddr_q, isram_rdata, beat_err};
      end
      // A redirect flushes everything, overriding any pop in the same cycle.
      if (redirect_valid) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         arvalid_q  <= 1'b0;
         araddr_q   <= '0;
         fetch_pc_q <= RESET_PC;
         discard_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         arvalid_q  <= arvalid_d;
         araddr_q   <= araddr_d;
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head          = mem_q[rd_ptr_q];
   assign isram_arvalid = arvalid_q;
   assign isram_araddr  = araddr_q;
   assign isram_rready  = (state_q == RESP);
   assign out_valid     = (count_q != '0);
   assign out_pc        = head[ENTRY_W-1 -: DATA_WIDTH];
   assign out_inst      = head[DATA_WIDTH:1];
   assign out_err       = head[0];

endmodule

// File: tb/tb_ysyx_23060208_ifu_prefetch.sv
// Scoreboard bench for the prefetcher: a behavioural SRAM slave answers reads and
// expected {pc, inst, err} entries queued per scenario are compared as the DUT emits them.
module tb_ysyx_23060208_ifu_prefetch;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } expEntry_t;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] isram_araddr;
   logic        isram_arvalid;
   logic        isram_arready;
   logic [31:0] isram_rdata;
   logic [1:0]  isram_rresp;
   logic        isram_rvalid;
   logic        isram_rready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_err;

   int          testCount = 0;
   int          failCount = 0;
   int          cycle = 0;
   expEntry_t   expQ[$];

   int          arDelay = 0;
   int          rDelay = 0;
   logic [31:0] errAddr = 32'hFFFF_FFFF;
   int          arCount = 0;
   int          rCount = 0;

   ysyx_23060208_ifu_prefetch #(
      .DATA_WIDTH (32),
      .FIFO_DEPTH (4),
      .RESET_PC   (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .isram_araddr   (isram_araddr),
      .isram_arvalid  (isram_arvalid),
      .isram_arready  (isram_arready),
      .isram_rdata    (isram_rdata),
      .isram_rresp    (isram_rresp),
      .isram_rvalid   (isram_rvalid),
      .isram_rready   (isram_rready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_err        (out_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] instFor(input logic [31:0] addr);
      return {addr[15:0], addr[31:16]} ^ 32'h0000_0013;
   endfunction

   // SRAM slave: all decisions at the falling edge; a handshake seen here fires on the next rising edge.
   initial begin
      logic        arWillFire = 1'b0;
      logic        rWillFire = 1'b0;
      logic [31:0] arWillAddr = '0;
      logic        pending = 1'b0;
      logic [31:0] pendAddr = '0;
      int          arCnt = 0;
      int          rCnt = 0;
      isram_arready = 1'b0;
      isram_rvalid  = 1'b0;
      isram_rdata   = '0;
      isram_rresp   = 2'b00;
      forever begin
         @(negedge clk);
         if (rst) begin
            isram_arready = 1'b0;
            isram_rvalid  = 1'b0;
            pending       = 1'b0;
            arCnt         = 0;
            rCnt          = 0;
            arCount       = 0;
            rCount        = 0;
         end else begin
            if (rWillFire) begin
               isram_rvalid = 1'b0;
               pending      = 1'b0;
               rCount++;
            end
            if (arWillFire) begin
               pending  = 1'b1;
               pendAddr = arWillAddr;
               rCnt     = 0;
               arCount++;
            end
            if (isram_arvalid && !pending) begin
               if (arCnt >= arDelay) begin
                  isram_arready = 1'b1;
               end else begin
                  arCnt++;
                  isram_arready = 1'b0;
               end
            end else begin
               isram_arready = 1'b0;
               arCnt         = 0;
            end
            if (pending && !isram_rvalid) begin
               if (rCnt >= rDelay) begin
                  isram_rvalid = 1'b1;
                  isram_rdata  = instFor(pendAddr);
                  isram_rresp  = (pendAddr == errAddr) ? 2'b10 : 2'b00;
               end else begin
                  rCnt++;
               end
            end
         end
         arWillFire = isram_arvalid && isram_arready && !rst;
         arWillAddr = isram_araddr;
         rWillFire  = isram_rvalid && isram_rready && !rst;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   task automatic pushExpected(input logic [31:0] startPc, input int n);
      for (int i = 0; i < n; i++) begin
         expEntry_t e;
         e.pc   = startPc + 32'(4 * i);
         e.inst = instFor(e.pc);
         e.err  = (e.pc == errAddr);
         expQ.push_back(e);
      end
   endtask

   // One cycle: consume only when an entry is expected, and compare what is consumed.
   task automatic tick();
      expEntry_t e;
      @(negedge clk);
      cycle++;
      out_ready = (expQ.size() > 0);
      if (out_valid && out_ready) begin
         e = expQ.pop_front();
         checkOutput("outPc", 64'(out_pc), 64'(e.pc));
         checkOutput("outInst", 64'(out_inst), 64'(e.inst));
         checkOutput("outErr", 64'(out_err), 64'(e.err));
      end
   endtask

   task automatic waitDrain(input string tag, input int maxCycles);
      int n = 0;
      while (expQ.size() > 0 && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput({"drain_", tag}, 64'(expQ.size()), 64'h0);
      expQ.delete();
   endtask

   task automatic waitFor(input string what, input int maxCycles);
      int n = 0;
      logic hit;
      forever begin
         case (what)
            "rready":   hit = isram_rready;
            "arvalid":  hit = isram_arvalid;
            "twoBeats": hit = (rCount >= 2);
            default:    hit = 1'b1;
         endcase
         if (hit || n >= maxCycles) break;
         tick();
         n++;
      end
      checkOutput({"waitFor_", what}, 64'(hit), 64'h1);
   endtask

   task automatic resetDut();
      expQ.delete();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      repeat (3) tick();
      checkOutput("rstOutValid", 64'(out_valid), 64'h0);
      checkOutput("rstArvalid", 64'(isram_arvalid), 64'h0);
      checkOutput("rstRready", 64'(isram_rready), 64'h0);
      checkOutput("rstAraddr", 64'(isram_araddr), 64'h0);
      rst = 1'b0;
      #1;
      checkOutput("firstCycleArvalid", 64'(isram_arvalid), 64'h0);
      tick();
      checkOutput("secondCycleArvalid", 64'(isram_arvalid), 64'h1);
      checkOutput("secondCycleAraddr", 64'(isram_araddr), 64'(RESET_PC));
   endtask

   // Redirect for one cycle; the flush makes the new stream the only expected output.
   task automatic applyStimulus(input logic [31:0] pc, input int n);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      expQ.delete();
      pushExpected(pc, n);
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      int startCycle;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;

      // Streaming with a fast slave.
      resetDut();
      startCycle = cycle;
      pushExpected(RESET_PC, 8);
      waitDrain("stream", 100);
      checkOutput("streamNoGaps", 64'((cycle - startCycle) <= 26), 64'h1);

      // Backpressure: four entries buffered, then drained in order and fetch resumes.
      resetDut();
      repeat (30) tick();
      checkOutput("bpArCount", 64'(arCount), 64'h4);
      checkOutput("bpArvalid", 64'(isram_arvalid), 64'h0);
      checkOutput("bpOutValid", 64'(out_valid), 64'h1);
      checkOutput("bpHeadPc", 64'(out_pc), 64'(RESET_PC));
      pushExpected(RESET_PC, 8);
      waitDrain("backpressure", 100);

      // Redirect during RESP with a slow response.
      rDelay = 2;
      resetDut();
      waitFor("rready", 20);
      applyStimulus(32'h8000_1000, 3);
      waitDrain("redirectResp", 100);
      rDelay = 0;

      // Redirect in the very cycle the beat is accepted.
      resetDut();
      waitFor("rready", 20);
      applyStimulus(32'h8000_3000, 2);
      waitDrain("redirectBeat", 100);

      // Redirect while AR is stalled.
      arDelay = 3;
      resetDut();
      waitFor("arvalid", 20);
      applyStimulus(32'h8000_2000, 2);
      for (int i = 0; i < 3; i++) begin
         checkOutput("arStableValid", 64'(isram_arvalid), 64'h1);
         checkOutput("arStableAddr", 64'(isram_araddr), 64'(RESET_PC));
         if (i < 2) tick();
      end
      arDelay = 0;
      waitDrain("redirectAddr", 100);

      // Error response halts fetching until a redirect.
      errAddr = 32'h8000_0008;
      resetDut();
      pushExpected(RESET_PC, 3);
      waitDrain("errStream", 100);
      repeat (10) tick();
      checkOutput("haltArCount", 64'(arCount), 64'h3);
      checkOutput("haltArvalid", 64'(isram_arvalid), 64'h0);
      applyStimulus(32'h8000_0100, 2);
      waitDrain("errResume", 100);
      errAddr = 32'hFFFF_FFFF;

      // Reset while a read is outstanding and two entries are buffered.
      rDelay = 2;
      resetDut();
      waitFor("twoBeats", 40);
      waitFor("rready", 20);
      checkOutput("preRstOutValid", 64'(out_valid), 64'h1);
      checkOutput("preRstHeadPc", 64'(out_pc), 64'(RESET_PC));
      rst = 1'b1;
      tick();
      checkOutput("midRstOutValid", 64'(out_valid), 64'h0);
      checkOutput("midRstArvalid", 64'(isram_arvalid), 64'h0);
      checkOutput("midRstRready", 64'(isram_rready), 64'h0);
      rDelay = 0;
      resetDut();
      pushExpected(RESET_PC, 2);
      waitDrain("afterReset", 100);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
